mips_control_unit: RTL and testbench
====================================

MIPS_CONTROL_UNIT -- requirements
Module: mips_control_unit

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 Op  input  6  opcode, IR[31:26], from datapath.
REQ-004 Funct  input  6  function field, IR[5:0], from datapath.
REQ-005 IorD, MemWrite, IRWrite, PCWrite, BranchEq, BranchNeq, PCSrc, ALUSrcA, RegWrite, MemtoReg, RegDst  output  1 each  datapath control strobes/selects.
REQ-006 ALUSrcB  output  2  ALU B select: 00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-007 ALUControl  output  4  ALU op: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
REQ-008 State  output  4  current FSM state encoding, for bench/debug only.

Function
REQ-009 Block SHALL be a Moore FSM; outputs are combinational from State, with ALUControl in EXECUTE also depending on Funct.
REQ-010 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, ADDIEXEC, ADDIWB, BRANCH.
REQ-011 Every output not listed for a state SHALL be 0 in that state.
REQ-012 FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUControl=0010; next DECODE.
REQ-013 DECODE: ALUSrcB=11, ALUControl=0010 (branch target precompute); next by Op: 100011/101011->MEMADR, 000000->EXECUTE, 001000->ADDIEXEC, 000100/000101->BRANCH, any other->FETCH.
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=0010; next MEMREAD if Op=100011, else MEMWRITE.
REQ-015 MEMREAD: IorD=1; next MEMWB.  MEMWB: RegWrite=1, MemtoReg=1; next FETCH.
REQ-016 MEMWRITE: IorD=1, MemWrite=1; next FETCH.
REQ-017 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl by Funct (100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, other->0010); next ALUWB.
REQ-018 ALUWB: RegWrite=1, RegDst=1; next FETCH.
REQ-019 ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=0010; next ADDIWB.  ADDIWB: RegWrite=1, RegDst=0; next FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=0110, PCSrc=1, BranchEq=(Op==000100), BranchNeq=(Op==000101); next FETCH.
REQ-021 Cycle counts per instruction: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, undefined opcode 2.
REQ-022 Unknown Funct in EXECUTE SHALL still write back (add); no exception state exists.
REQ-023 Unreachable state encodings SHALL transition to FETCH with all outputs 0.

Reset
REQ-024 reset=1 SHALL force State=FETCH immediately, regardless of clk, including mid-instruction.
REQ-025 While reset=1, PCWrite, IRWrite, MemWrite and RegWrite SHALL be 0; FETCH outputs take effect only after reset deasserts.
REQ-026 First rising edge after reset deassertion SHALL execute FETCH (instruction at PC latched).

Structure
REQ-027 Shared package mips_pkg SHALL hold: state enum, opcode constants, funct constants, ALUControl codes, ALUSrcB select codes.
REQ-028 One sub-module, mips_alu_decoder (combinational Funct/state -> ALUControl), SHALL be instantiated; main FSM holds state register and next-state/output logic.

Verification
REQ-029 Reset 9 ns then Op=001000 (addi $t1,$zero,3): States FETCH, DECODE, ADDIEXEC, ADDIWB; ADDIWB shows RegWrite=1, RegDst=0; then FETCH.
REQ-030 Op=000000, Funct=100000 (add $t1,$t1,$t1): EXECUTE shows ALUSrcA=1, ALUSrcB=00, ALUControl=0010; ALUWB shows RegWrite=1, RegDst=1.
REQ-031 Op=100011 (lw): 5 cycles; MEMREAD IorD=1; MEMWB RegWrite=1, MemtoReg=1.  Op=101011 (sw): MEMWRITE MemWrite=1, IorD=1, 4 cycles.
REQ-032 Op=000101 (bne): BRANCH shows BranchNeq=1, BranchEq=0, PCSrc=1, ALUControl=0110; next FETCH after 3 cycles.
REQ-033 Op=111111: DECODE -> FETCH, no RegWrite/MemWrite pulse; reset asserted during MEMREAD -> State=FETCH before next edge, IorD=0.
REQ-034 Back-to-back sequence addi, addi, add, add integrated with MIPS_Multi_Cycle: final GPIO/register values match the hand-driven control-signal run.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: FSM state
// encoding, instruction field constants and datapath select codes.
package mips_pkg;

    // Controller states; encodings 11..15 are unused and recover to fetch.
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StAddiExec = 4'd8,
        StAddiWb   = 4'd9,
        StBranch   = 4'd10
    } state_e;

    // Opcodes, IR[31:26]
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;

    // R-type function codes, IR[5:0]
    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;

    // ALU B-operand select codes
    localparam logic [1:0] SrcbReg    = 2'b00;
    localparam logic [1:0] SrcbFour   = 2'b01;
    localparam logic [1:0] SrcbImm    = 2'b10;
    localparam logic [1:0] SrcbImmSh2 = 2'b11;

    // Loads and stores share the address-computation state.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OpLw) || (op == OpSw);
    endfunction

    // Both conditional branches share the compare state.
    function automatic logic is_branch_op(input logic [5:0] op);
        return (op == OpBeq) || (op == OpBne);
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU operation select from controller state and R-type funct.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] funct,
    output logic [3:0] alu_control
);

    // Funct matters only in EXECUTE; unknown functs fall back to add so
    // the instruction still writes a result.
    always_comb begin
        alu_control = AluAnd;
        case (state)
            StFetch, StDecode, StMemAdr, StAddiExec: alu_control = AluAdd;
            StBranch:                                alu_control = AluSub;
            StExecute: begin
                case (funct)
                    FunctAdd: alu_control = AluAdd;
                    FunctSub: alu_control = AluSub;
                    FunctAnd: alu_control = AluAnd;
                    FunctOr:  alu_control = AluOr;
                    FunctSlt: alu_control = AluSlt;
                    default:  alu_control = AluAdd;
                endcase
            end
            default: alu_control = AluAnd;
        endcase
    end

endmodule

// File: rtl/mips_control_unit.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch, decode and
// per-class execute/writeback steps, driving datapath strobes and selects.
module mips_control_unit
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       BranchEq,
    output logic       BranchNeq,
    output logic       PCSrc,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [3:0] State
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] alu_ctrl;

    // State register; reset forces fetch without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; Op is held by the IR for the whole instruction.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                if (is_mem_op(Op)) begin
                    state_d = StMemAdr;
                end else if (Op == OpRtype) begin
                    state_d = StExecute;
                end else if (Op == OpAddi) begin
                    state_d = StAddiExec;
                end else if (is_branch_op(Op)) begin
                    state_d = StBranch;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemAdr:   state_d = (Op == OpLw) ? StMemRead : StMemWrite;
            StMemRead:  state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = StFetch;
            StExecute:  state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StAddiExec: state_d = StAddiWb;
            StAddiWb:   state_d = StFetch;
            StBranch:   state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .state       (state_q),
        .funct       (Funct),
        .alu_control (alu_ctrl)
    );

    // Moore outputs; everything is held low while reset is asserted so the
    // fetch strobes cannot fire before reset releases.
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        BranchEq   = 1'b0;
        BranchNeq  = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcA    = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        ALUSrcB    = SrcbReg;
        ALUControl = AluAnd;
        if (!reset) begin
            ALUControl = alu_ctrl;
            case (state_q)
                StFetch: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = SrcbFour;
                end
                // Branch target computed speculatively during decode.
                StDecode: ALUSrcB = SrcbImmSh2;
                StMemAdr: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SrcbImm;
                end
                StMemRead: IorD = 1'b1;
                StMemWb: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                StMemWrite: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                StExecute: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SrcbReg;
                end
                StAluWb: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                StAddiExec: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SrcbImm;
                end
                StAddiWb: RegWrite = 1'b1;
                StBranch: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SrcbReg;
                    PCSrc     = 1'b1;
                    BranchEq  = (Op == OpBeq);
                    BranchNeq = (Op == OpBne);
                end
                default: ALUControl = AluAnd;
            endcase
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_mips_control_unit.sv
// Self-checking bench: instruction-level model of the controller compared
// every cycle, plus literal spot checks of key states and cycle counts.
module tb_mips_control_unit;
    import mips_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       IorD, MemWrite, IRWrite, PCWrite, BranchEq, BranchNeq, PCSrc;
    logic       ALUSrcA, RegWrite, MemtoReg, RegDst;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic [3:0] State;

    mips_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .BranchEq   (BranchEq),
        .BranchNeq  (BranchNeq),
        .PCSrc      (PCSrc),
        .ALUSrcA    (ALUSrcA),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction phases as seen by the model.
    localparam int KF = 0, KD = 1, KMA = 2, KMR = 3, KMWB = 4, KMW = 5;
    localparam int KEX = 6, KAWB = 7, KAE = 8, KAIWB = 9, KBR = 10;

    typedef struct packed {
        logic       iord, memwrite, irwrite, pcwrite, beq, bne, pcsrc;
        logic       srca, regwrite, memtoreg, regdst;
        logic [1:0] srcb;
        logic [3:0] alu;
        logic [3:0] st;
    } out_t;

    int n_cmp = 0;
    int n_err = 0;

    // Model state, driven by the stimulus process.
    int         seq [5];
    int         seq_len;
    int         idx;
    int         exp_step;
    logic [5:0] cur_op;
    logic [5:0] cur_funct;
    bit         in_reset;
    bit         check_en;

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic logic [3:0] phase_state(input int k);
        case (k)
            KF:      return StFetch;
            KD:      return StDecode;
            KMA:     return StMemAdr;
            KMR:     return StMemRead;
            KMWB:    return StMemWb;
            KMW:     return StMemWrite;
            KEX:     return StExecute;
            KAWB:    return StAluWb;
            KAE:     return StAddiExec;
            KAIWB:   return StAddiWb;
            default: return StBranch;
        endcase
    endfunction

    // Expected outputs for a phase, straight from the per-state output table.
    function automatic out_t model_out(input int k, input logic [5:0] op,
                                       input logic [5:0] f, input bit rst);
        out_t o;
        o = '0;
        if (rst) begin
            o.st = StFetch;
            return o;
        end
        o.st = phase_state(k);
        case (k)
            KF:    begin o.irwrite = 1; o.pcwrite = 1; o.srcb = 2'b01; o.alu = 4'b0010; end
            KD:    begin o.srcb = 2'b11; o.alu = 4'b0010; end
            KMA:   begin o.srca = 1; o.srcb = 2'b10; o.alu = 4'b0010; end
            KMR:   o.iord = 1;
            KMWB:  begin o.regwrite = 1; o.memtoreg = 1; end
            KMW:   begin o.iord = 1; o.memwrite = 1; end
            KEX:   begin o.srca = 1; o.alu = funct_alu(f); end
            KAWB:  begin o.regwrite = 1; o.regdst = 1; end
            KAE:   begin o.srca = 1; o.srcb = 2'b10; o.alu = 4'b0010; end
            KAIWB: o.regwrite = 1;
            default: begin
                o.srca = 1; o.alu = 4'b0110; o.pcsrc = 1;
                o.beq = (op == 6'b000100);
                o.bne = (op == 6'b000101);
            end
        endcase
        return o;
    endfunction

    // Phase list an instruction walks through, derived from its opcode.
    task automatic build_seq(input logic [5:0] op);
        seq[0] = KF;
        seq[1] = KD;
        case (op)
            6'b100011: begin seq[2] = KMA; seq[3] = KMR; seq[4] = KMWB; seq_len = 5; end
            6'b101011: begin seq[2] = KMA; seq[3] = KMW; seq_len = 4; end
            6'b000000: begin seq[2] = KEX; seq[3] = KAWB; seq_len = 4; end
            6'b001000: begin seq[2] = KAE; seq[3] = KAIWB; seq_len = 4; end
            6'b000100, 6'b000101: begin seq[2] = KBR; seq_len = 3; end
            default: seq_len = 2;
        endcase
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        out_t e, a;
        if (check_en) begin
            e = model_out(exp_step, cur_op, cur_funct, in_reset);
            a = '{IorD, MemWrite, IRWrite, PCWrite, BranchEq, BranchNeq, PCSrc,
                  ALUSrcA, RegWrite, MemtoReg, RegDst, ALUSrcB, ALUControl, State};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL cycle op=%b funct=%b phase=%0d: actual %h required %h",
                         cur_op, cur_funct, exp_step, a, e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic start(input logic [5:0] op, input logic [5:0] f);
        Op = op;
        Funct = f;
        cur_op = op;
        cur_funct = f;
        build_seq(op);
        idx = 0;
        exp_step = seq[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idx++;
        exp_step = (idx < seq_len) ? seq[idx] : KF;
    endtask

    task automatic run_all(input logic [5:0] op, input logic [5:0] f);
        start(op, f);
        repeat (seq_len) step();
    endtask

    // Count edges from fetch back to fetch using literal expectations.
    task automatic measure(input string name, input logic [5:0] op, input int exp_cycles);
        int n;
        check_en = 0;
        Op = op;
        Funct = 6'b100000;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (State != StFetch && n < 12);
        check(name, n, exp_cycles);
        exp_step = KF;
        check_en = 1;
    endtask

    initial begin
        logic [5:0] op, f;
        logic [5:0] functs [5];
        functs[0] = 6'b100000; functs[1] = 6'b100010; functs[2] = 6'b100100;
        functs[3] = 6'b100101; functs[4] = 6'b101010;

        reset = 1; Op = 0; Funct = 0; cur_op = 0; cur_funct = 0;
        in_reset = 1; check_en = 0; exp_step = KF; seq_len = 2; idx = 0;
        #1;
        check("reset_state", State, StFetch);
        check("reset_strobes", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
        check_en = 1;
        #8;
        reset = 0;
        in_reset = 0;

        // addi $t1,$zero,3
        start(6'b001000, 6'b000000);
        step(); check("addi_decode", State, StDecode);
        step(); check("addi_exec", State, StAddiExec);
        step(); check("addi_wb", {State, RegWrite, RegDst}, {StAddiWb, 2'b10});
        step(); check("addi_back_fetch", State, StFetch);

        // add $t1,$t1,$t1
        start(6'b000000, 6'b100000);
        step(); step();
        check("add_exec", {ALUSrcA, ALUSrcB, ALUControl}, 7'b1_00_0010);
        step();
        check("add_wb", {RegWrite, RegDst}, 2'b11);
        step();

        // lw and sw
        start(6'b100011, 6'b0);
        step(); step(); step();
        check("lw_memread", {State, IorD}, {StMemRead, 1'b1});
        step();
        check("lw_memwb", {RegWrite, MemtoReg}, 2'b11);
        step();
        start(6'b101011, 6'b0);
        step(); step(); step();
        check("sw_memwrite", {MemWrite, IorD}, 2'b11);
        step();

        // bne
        start(6'b000101, 6'b0);
        step(); step();
        check("bne_branch", {BranchNeq, BranchEq, PCSrc, ALUControl}, 7'b1_0_1_0110);
        step();
        check("bne_back_fetch", State, StFetch);

        // Undefined opcode and unknown funct
        run_all(6'b111111, 6'b0);
        run_all(6'b000000, 6'b111111);

        // Cycle counts
        measure("cycles_lw", 6'b100011, 5);
        measure("cycles_sw", 6'b101011, 4);
        measure("cycles_rtype", 6'b000000, 4);
        measure("cycles_addi", 6'b001000, 4);
        measure("cycles_beq", 6'b000100, 3);
        measure("cycles_undef", 6'b111111, 2);

        // Asynchronous reset in the middle of a load
        start(6'b100011, 6'b0);
        step(); step(); step();
        #2;
        reset = 1;
        in_reset = 1;
        exp_step = KF;
        #1;
        check("midreset_state", State, StFetch);
        check("midreset_iord", IorD, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_state", State, StFetch);
        #1;
        reset = 0;
        in_reset = 0;
        run_all(6'b001000, 6'b0);

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b001000;
                4: op = 6'b000100;
                5: op = 6'b000101;
                default: op = 6'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 1) == 0) f = functs[$urandom_range(0, 4)];
            else f = 6'($urandom_range(0, 63));
            run_all(op, f);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
